factor_search_ctrl: RTL and testbench

FACTOR_SEARCH_CTRL -- requirements
Module: factor_search_ctrl

---
 rtl/factor_search_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_factor_search_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/factor_search_ctrl.sv
// Mersenne trial-factoring sequencer: walks d = 2kp+1 for k = 1..kmax and hands each candidate to a factoring core.
// Optional macro MOD8_FILTER_EN skips candidates with d mod 8 not in {1,7} without issuing them to the core.
//
// state | meaning
// IDLE  | waiting for a search command
// NEXT  | current candidate (k, d) loaded; decide whether to issue or skip it
// ISSUE | one-cycle core_start pulse with core_p/core_d
// WAIT  | waiting for core_finished, bounded by WAIT_TIMEOUT
// DONE  | result held on res_* until res_ready
module factor_search_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 65535
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_p,
    input  logic [31:0] cmd_kmax,
    output logic        core_start,
    output logic [31:0] core_p,
    output logic [31:0] core_d,
    input  logic        core_isPrime,
    input  logic        core_finished,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_found,
    output logic        res_ovf,
    output logic        res_timeout,
    output logic [31:0] res_factor,
    output logic [31:0] res_k,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEXT  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [31:0] TIMEOUT_LOAD = 32'(WAIT_TIMEOUT);

    state_t      state, state_nx;
    logic [31:0] p_q, p_nx;
    logic [31:0] kmax_q, kmax_nx;
    logic [31:0] k_q, k_nx;
    logic [31:0] d_q, d_nx;
    logic [31:0] wait_cnt, wait_cnt_nx;
    logic        found_q, found_nx;
    logic        ovf_q, ovf_nx;
    logic        tmo_q, tmo_nx;
    logic        armed_q;

    logic [31:0] two_p;
    logic [32:0] d_sum;
    logic        last_k;
    logic        keep;
    logic        wait_tc;
    logic        step;

    assign two_p   = {p_q[30:0], 1'b0};
    assign d_sum   = {1'b0, d_q} + {1'b0, two_p};
    assign last_k  = (k_q == kmax_q);
    assign wait_tc = (TIMEOUT_LOAD != 32'd0) && (wait_cnt == 32'd1);

`ifdef MOD8_FILTER_EN
    // Prime factors of 2^p-1 are always +-1 mod 8; other candidates cannot divide it.
    assign keep = (d_q[2:0] == 3'd1) || (d_q[2:0] == 3'd7);
`else
    assign keep = 1'b1;
`endif

    always_comb begin
        state_nx    = state;
        p_nx        = p_q;
        kmax_nx     = kmax_q;
        k_nx        = k_q;
        d_nx        = d_q;
        wait_cnt_nx = wait_cnt;
        found_nx    = found_q;
        ovf_nx      = ovf_q;
        tmo_nx      = tmo_q;
        step        = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    p_nx     = cmd_p;
                    kmax_nx  = cmd_kmax;
                    found_nx = 1'b0;
                    ovf_nx   = 1'b0;
                    tmo_nx   = 1'b0;
                    k_nx     = 32'd1;
                    d_nx     = {cmd_p[30:0], 1'b1};
                    if (cmd_p[31]) begin
                        ovf_nx   = 1'b1;
                        k_nx     = 32'd0;
                        d_nx     = 32'd0;
                        state_nx = DONE;
                    end else if (cmd_p == 32'd0 || cmd_kmax == 32'd0) begin
                        k_nx     = 32'd0;
                        d_nx     = 32'd0;
                        state_nx = DONE;
                    end else begin
                        state_nx = NEXT;
                    end
                end
            end
            NEXT: begin
                if (keep) begin
                    state_nx = ISSUE;
                end else begin
                    step = 1'b1;
                end
            end
            ISSUE: begin
                wait_cnt_nx = TIMEOUT_LOAD;
                state_nx    = WAIT;
            end
            WAIT: begin
                if (core_finished) begin
                    if (!core_isPrime) begin
                        found_nx = 1'b1;
                        state_nx = DONE;
                    end else begin
                        step = 1'b1;
                    end
                end else if (wait_tc) begin
                    tmo_nx   = 1'b1;
                    state_nx = DONE;
                end else if (wait_cnt != 32'd0) begin
                    wait_cnt_nx = wait_cnt - 32'd1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Shared advance to the next k; on overflow d/k keep the last evaluated candidate.
        if (step) begin
            if (last_k) begin
                state_nx = DONE;
            end else if (d_sum[32]) begin
                ovf_nx   = 1'b1;
                state_nx = DONE;
            end else begin
                k_nx     = k_q + 32'd1;
                d_nx     = d_sum[31:0];
                state_nx = NEXT;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            p_q      <= 32'd0;
            kmax_q   <= 32'd0;
            k_q      <= 32'd0;
            d_q      <= 32'd0;
            wait_cnt <= 32'd0;
            found_q  <= 1'b0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            p_q      <= p_nx;
            kmax_q   <= kmax_nx;
            k_q      <= k_nx;
            d_q      <= d_nx;
            wait_cnt <= wait_cnt_nx;
            found_q  <= found_nx;
            ovf_q    <= ovf_nx;
            tmo_q    <= tmo_nx;
            armed_q  <= 1'b1;
        end
    end

    // armed_q keeps cmd_ready low until the first edge after reset release.
    assign cmd_ready   = (state == IDLE) && armed_q;
    assign busy        = (state != IDLE);
    assign core_start  = (state == ISSUE);
    assign core_p      = p_q;
    assign core_d      = d_q;
    assign res_valid   = (state == DONE);
    assign res_found   = found_q;
    assign res_ovf     = ovf_q;
    assign res_timeout = tmo_q;
    assign res_factor  = d_q;
    assign res_k       = k_q;

endmodule

// File: tb/tb_factor_search_ctrl.sv
// Directed bench for factor_search_ctrl with a bit-accurate modular-exponentiation core model.
// Expected core_start counts follow the MOD8_FILTER_EN build setting.
module tb_factor_search_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_p = 32'd0;
    logic [31:0] cmd_kmax = 32'd0;
    logic        core_start;
    logic [31:0] core_p;
    logic [31:0] core_d;
    logic        core_isPrime;
    logic        core_finished;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        res_found;
    logic        res_ovf;
    logic        res_timeout;
    logic [31:0] res_factor;
    logic [31:0] res_k;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int starts = 0;
    int core_cnt;
    bit core_en = 1'b0;

    factor_search_ctrl #(.WAIT_TIMEOUT(16)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_p(cmd_p), .cmd_kmax(cmd_kmax),
        .core_start(core_start), .core_p(core_p), .core_d(core_d),
        .core_isPrime(core_isPrime), .core_finished(core_finished),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_found(res_found), .res_ovf(res_ovf), .res_timeout(res_timeout),
        .res_factor(res_factor), .res_k(res_k), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] pow2mod(input logic [31:0] p, input logic [31:0] d);
        logic [63:0] r;
        logic [63:0] b;
        r = 64'd1 % {32'd0, d};
        b = 64'd2 % {32'd0, d};
        for (int i = 0; i < 32; i++) begin
            if (p[i]) r = (r * b) % {32'd0, d};
            b = (b * b) % {32'd0, d};
        end
        return r[31:0];
    endfunction

    // Core model: answers three cycles after core_start when enabled.
    always @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            core_cnt = 0;
            core_finished = 1'b0;
            core_isPrime = 1'b0;
        end else begin
            core_finished = 1'b0;
            if (core_cnt > 0) begin
                core_cnt = core_cnt - 1;
                if (core_cnt == 0) core_finished = 1'b1;
            end
            if (core_start && core_en) begin
                core_isPrime = (pow2mod(core_p, core_d) != 32'd1);
                core_cnt = 3;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (core_start) starts = starts + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] p, input logic [31:0] kmax);
        int n;
        n = 0;
        while (!cmd_ready && n < 100) begin
            step();
            n++;
        end
        chk("cmd_ready_seen", {63'd0, cmd_ready}, 64'd1);
        cmd_p = p;
        cmd_kmax = kmax;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!res_valid && n < 2000) begin
            step();
            n++;
        end
        chk("result_arrives", {63'd0, res_valid}, 64'd1);
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("released_to_idle", {62'd0, res_valid, busy}, 64'd0);
    endtask

    task automatic wait_core_start();
        int n;
        n = 0;
        while (!core_start && n < 100) begin
            step();
            n++;
        end
        chk("core_start_seen", {63'd0, core_start}, 64'd1);
    endtask

    int s0;
    int n;
    logic [66:0] snap;
    int exp_starts_29;
    int exp_starts_13;

    initial begin
`ifdef MOD8_FILTER_EN
        exp_starts_29 = 2;
        exp_starts_13 = 2;
`else
        exp_starts_29 = 4;
        exp_starts_13 = 5;
`endif
        // Reset
        #2 sys_rst_n = 1'b0;
        #1;
        chk("reset_outputs", {cmd_ready, busy, core_start, res_valid, res_found, res_ovf, res_timeout},
            64'd0);
        chk("reset_data", {core_d, res_factor}, 64'd0);
        chk("reset_data2", {core_p, res_k}, 64'd0);
        #20 sys_rst_n = 1'b1;
        #1;
        chk("cmd_ready_before_edge", {63'd0, cmd_ready}, 64'd0);
        step();
        chk("cmd_ready_after_release", {63'd0, cmd_ready}, 64'd1);

        // p=11: 23 divides 2^11-1 at k=1
        core_en = 1'b1;
        s0 = starts;
        send_cmd(32'd11, 32'd10);
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        wait_result();
        chk("p11_flags", {61'd0, res_found, res_ovf, res_timeout}, 64'h4);
        chk("p11_factor", {32'd0, res_factor}, 64'd23);
        chk("p11_k", {32'd0, res_k}, 64'd1);
        chk("p11_starts", 64'(starts - s0), 64'd1);
        // Hold res_ready low for 10 cycles; result must not move.
        snap = {res_valid, res_found, res_ovf, res_timeout, res_factor, res_k[30:0]};
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_stable", 64'({res_valid, res_found, res_ovf, res_timeout, res_factor, res_k[30:0]}),
                64'(snap));
        end
        release_result();

        // p=29: 233 = 8*29+1 at k=4
        s0 = starts;
        send_cmd(32'd29, 32'd10);
        wait_result();
        chk("p29_flags", {61'd0, res_found, res_ovf, res_timeout}, 64'h4);
        chk("p29_factor", {32'd0, res_factor}, 64'd233);
        chk("p29_k", {32'd0, res_k}, 64'd4);
        chk("p29_starts", 64'(starts - s0), 64'(exp_starts_29));
        release_result();

        // p=13: 2^13-1 is prime, search exhausts at k=5 (d=131)
        s0 = starts;
        send_cmd(32'd13, 32'd5);
        wait_result();
        chk("p13_flags", {61'd0, res_found, res_ovf, res_timeout}, 64'h0);
        chk("p13_factor", {32'd0, res_factor}, 64'd131);
        chk("p13_k", {32'd0, res_k}, 64'd5);
        chk("p13_starts", 64'(starts - s0), 64'(exp_starts_13));
        release_result();

        // p=0 finishes the cycle after acceptance
        s0 = starts;
        send_cmd(32'd0, 32'd10);
        chk("p0_done_next_cycle", {62'd0, res_valid, res_found}, 64'h2);
        chk("p0_starts", 64'(starts - s0), 64'd0);
        release_result();

        // kmax=0 also finishes immediately
        send_cmd(32'd11, 32'd0);
        chk("kmax0_done", {61'd0, res_valid, res_found, res_ovf}, 64'h4);
        release_result();

        // p with bit 31 set: 2p overflows
        s0 = starts;
        send_cmd(32'h8000_0000, 32'd10);
        chk("pmsb_ovf", {60'd0, res_valid, res_found, res_ovf, res_timeout}, 64'hA);
        chk("pmsb_starts", 64'(starts - s0), 64'd0);
        release_result();

        // Timeout: core silent, WAIT entered one edge after the ISSUE cycle
        core_en = 1'b0;
        send_cmd(32'd11, 32'd10);
        wait_core_start();
        n = 0;
        while (!res_valid && n < 100) begin
            step();
            n++;
        end
        chk("timeout_latency", 64'(n), 64'd17);
        chk("timeout_flags", {61'd0, res_found, res_ovf, res_timeout}, 64'h1);
        chk("timeout_k", {32'd0, res_k}, 64'd1);
        release_result();

        // Asynchronous reset in the middle of WAIT
        send_cmd(32'd29, 32'd10);
        wait_core_start();
        step();
        step();
        chk("mid_wait_busy", {62'd0, busy, res_valid}, 64'h2);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("async_reset_flags", {cmd_ready, busy, core_start, res_valid, res_found, res_ovf, res_timeout},
            64'd0);
        chk("async_reset_core", {core_p, core_d}, 64'd0);
        chk("async_reset_res", {res_factor, res_k}, 64'd0);
        #12 sys_rst_n = 1'b1;
        core_en = 1'b1;
        s0 = starts;
        send_cmd(32'd11, 32'd3);
        wait_result();
        chk("post_reset_found", {61'd0, res_found, res_ovf, res_timeout}, 64'h4);
        chk("post_reset_factor", {32'd0, res_factor}, 64'd23);
        chk("post_reset_starts", 64'(starts - s0), 64'd1);
        release_result();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
